// File: rtl/draw_sequencer.sv
// Top-level VGA draw scheduler: clears the screen with the fillscreen engine, then
// runs the circle engine, forwarding the active engine's clipped pixels to the adapter.
//
// state    | meaning
// IDLE     | waiting for start; params latched on exit
// FILL     | fillscreen engine running
// FILL_REL | waiting for fillscreen engine to drop done
// CIRC     | circle engine running
// DONE     | run finished, waiting for start low
// ERR      | phase timed out, waiting for start low
module draw_sequencer #(
    parameter int SCREEN_W       = 160,
    parameter int SCREEN_H       = 120,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  bg_colour,
    input  logic [2:0]  fg_colour,
    input  logic [7:0]  centre_x,
    input  logic [6:0]  centre_y,
    input  logic [7:0]  radius,
    output logic        done,
    output logic        error,
    output logic [15:0] pixel_count,
    output logic        fill_start,
    output logic [2:0]  fill_colour,
    input  logic        fill_done,
    input  logic [7:0]  fill_x,
    input  logic [6:0]  fill_y,
    input  logic [2:0]  fill_col,
    input  logic        fill_plot,
    output logic        circ_start,
    output logic [7:0]  circ_cx,
    output logic [6:0]  circ_cy,
    output logic [7:0]  circ_r,
    output logic [2:0]  circ_colour,
    input  logic        circ_done,
    input  logic [7:0]  circ_x,
    input  logic [6:0]  circ_y,
    input  logic [2:0]  circ_col,
    input  logic        circ_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot
);

    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [8:0]    X_LIM     = 9'(SCREEN_W);
    localparam logic [7:0]    Y_LIM     = 8'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_FILL_REL, S_CIRC, S_DONE, S_ERR
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic          timeout;
    logic          start_run;
    logic          sel_plot;
    logic [7:0]    sel_x;
    logic [6:0]    sel_y;
    logic [2:0]    sel_col;
    logic          plot_ok;

    assign timeout   = (timer + TW'(1)) == TIMER_MAX;
    assign start_run = (state == S_IDLE) && start;
    assign plot_ok   = sel_plot && ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Abort beats engine completion, which beats timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (start) state_next = S_FILL;
            S_FILL: begin
                if (!start)         state_next = S_IDLE;
                else if (fill_done) state_next = S_FILL_REL;
                else if (timeout)   state_next = S_ERR;
            end
            S_FILL_REL: begin
                if (!start)          state_next = S_IDLE;
                else if (!fill_done) state_next = S_CIRC;
                else if (timeout)    state_next = S_ERR;
            end
            S_CIRC: begin
                if (!start)         state_next = S_IDLE;
                else if (circ_done) state_next = S_DONE;
                else if (timeout)   state_next = S_ERR;
            end
            S_DONE, S_ERR: if (!start) state_next = S_IDLE;
            default:        state_next = S_IDLE;
        endcase
    end

    // Gating the mux with start keeps the abort cycle from plotting.
    always_comb begin
        fill_start = (state == S_FILL);
        circ_start = (state == S_CIRC);
        done       = (state == S_DONE) || (state == S_ERR);
        error      = (state == S_ERR);
        sel_plot   = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_col    = '0;
        if (start && state == S_FILL) begin
            sel_plot = fill_plot;
            sel_x    = fill_x;
            sel_y    = fill_y;
            sel_col  = fill_col;
        end else if (start && state == S_CIRC) begin
            sel_plot = circ_plot;
            sel_x    = circ_x;
            sel_y    = circ_y;
            sel_col  = circ_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer       <= '0;
            fill_colour <= '0;
            circ_cx     <= '0;
            circ_cy     <= '0;
            circ_r      <= '0;
            circ_colour <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            pixel_count <= '0;
        end else begin
            if (state_next != state)
                timer <= '0;
            else if (state == S_FILL || state == S_FILL_REL || state == S_CIRC)
                timer <= timer + TW'(1);

            if (start_run) begin
                fill_colour <= bg_colour;
                circ_cx     <= centre_x;
                circ_cy     <= centre_y;
                circ_r      <= radius;
                circ_colour <= fg_colour;
            end

            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_col;
            vga_plot   <= plot_ok;

            if (start_run)
                pixel_count <= '0;
            else if (plot_ok && pixel_count != 16'hFFFF)
                pixel_count <= pixel_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: a vector table for the single-cycle behaviour plus
// hand sequences for the full run, abort/relatch, reset and timeout.
module tb_draw_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, start_to;
    logic [2:0]  bg_colour, fg_colour;
    logic [7:0]  centre_x, radius;
    logic [6:0]  centre_y;
    logic        fill_done, fill_done_to, circ_done;
    logic [7:0]  fill_x, circ_x;
    logic [6:0]  fill_y, circ_y;
    logic [2:0]  fill_col, circ_col;
    logic        fill_plot, circ_plot;

    logic        done, error, fill_start, circ_start, vga_plot;
    logic [15:0] pixel_count;
    logic [2:0]  fill_colour, circ_colour, vga_colour;
    logic [7:0]  circ_cx, circ_r, vga_x;
    logic [6:0]  circ_cy, vga_y;

    logic        done_t, error_t, fill_start_t, circ_start_t, vga_plot_t;
    logic [15:0] pixel_count_t;
    logic [2:0]  fill_colour_t, circ_colour_t, vga_colour_t;
    logic [7:0]  circ_cx_t, circ_r_t, vga_x_t;
    logic [6:0]  circ_cy_t, vga_y_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    draw_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .bg_colour(bg_colour), .fg_colour(fg_colour),
        .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
        .done(done), .error(error), .pixel_count(pixel_count),
        .fill_start(fill_start), .fill_colour(fill_colour), .fill_done(fill_done),
        .fill_x(fill_x), .fill_y(fill_y), .fill_col(fill_col), .fill_plot(fill_plot),
        .circ_start(circ_start), .circ_cx(circ_cx), .circ_cy(circ_cy), .circ_r(circ_r),
        .circ_colour(circ_colour), .circ_done(circ_done),
        .circ_x(circ_x), .circ_y(circ_y), .circ_col(circ_col), .circ_plot(circ_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    draw_sequencer #(.TIMEOUT_CYCLES(100)) dut_to (
        .clk(clk), .rst(rst), .start(start_to),
        .bg_colour(bg_colour), .fg_colour(fg_colour),
        .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
        .done(done_t), .error(error_t), .pixel_count(pixel_count_t),
        .fill_start(fill_start_t), .fill_colour(fill_colour_t), .fill_done(fill_done_to),
        .fill_x(fill_x), .fill_y(fill_y), .fill_col(fill_col), .fill_plot(fill_plot),
        .circ_start(circ_start_t), .circ_cx(circ_cx_t), .circ_cy(circ_cy_t), .circ_r(circ_r_t),
        .circ_colour(circ_colour_t), .circ_done(circ_done),
        .circ_x(circ_x), .circ_y(circ_y), .circ_col(circ_col), .circ_plot(circ_plot),
        .vga_x(vga_x_t), .vga_y(vga_y_t), .vga_colour(vga_colour_t), .vga_plot(vga_plot_t)
    );

    typedef struct {
        logic        start, fd, cd;
        logic        fp;
        logic [7:0]  fx;
        logic [6:0]  fy;
        logic        cp;
        logic [7:0]  cx;
        logic [6:0]  cy;
        logic [4:0]  flags;   // {done, error, fill_start, circ_start, vga_plot}
        logic [7:0]  ex;
        logic [6:0]  ey;
        logic [2:0]  ecol;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input int s, input int fd, input int cd,
                                input int fp, input int fx, input int fy,
                                input int cp, input int cx, input int cy,
                                input int flags, input int ex, input int ey,
                                input int ecol, input int ecnt);
        vec_t v;
        v.start = s[0];   v.fd = fd[0];      v.cd = cd[0];
        v.fp    = fp[0];  v.fx = 8'(fx);     v.fy = 7'(fy);
        v.cp    = cp[0];  v.cx = 8'(cx);     v.cy = 7'(cy);
        v.flags = 5'(flags);
        v.ex    = 8'(ex); v.ey = 7'(ey);     v.ecol = 3'(ecol);
        v.ecnt  = 16'(ecnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; start_to = 1'b0;
        bg_colour = 3'd0; fg_colour = 3'd0; centre_x = 8'd0; centre_y = 7'd0; radius = 8'd0;
        fill_done = 1'b0; fill_done_to = 1'b0; circ_done = 1'b0;
        fill_x = 8'd0; fill_y = 7'd0; fill_col = 3'd0; fill_plot = 1'b0;
        circ_x = 8'd0; circ_y = 7'd0; circ_col = 3'd0; circ_plot = 1'b0;

        // Rows: start fd cd | fill px | circ px | {done,err,fs,cs,vp} x y col count
        vecs[0]  = mk(1,0,0, 0,  0,  0, 0,  0,  0, 'b00100,   0,  0, 0, 0);
        vecs[1]  = mk(1,0,0, 1,  1,  1, 1,  2,  2, 'b00101,   1,  1, 5, 1);
        vecs[2]  = mk(1,0,0, 0,  0,  0, 1,  1,  1, 'b00100,   0,  0, 0, 1);
        vecs[3]  = mk(1,0,0, 1,159,119, 0,  0,  0, 'b00101, 159,119, 5, 2);
        vecs[4]  = mk(1,0,0, 1,160,  5, 0,  0,  0, 'b00100,   0,  0, 0, 2);
        vecs[5]  = mk(1,1,0, 1,  3,  4, 0,  0,  0, 'b00001,   3,  4, 5, 3);
        vecs[6]  = mk(1,1,0, 1,  7,  7, 0,  0,  0, 'b00000,   0,  0, 0, 3);
        vecs[7]  = mk(1,0,0, 0,  0,  0, 0,  0,  0, 'b00010,   0,  0, 0, 3);
        vecs[8]  = mk(1,0,0, 1,  5,  5, 1,170, 10, 'b00010,   0,  0, 0, 3);
        vecs[9]  = mk(1,0,0, 0,  0,  0, 1,  5,125, 'b00010,   0,  0, 0, 3);
        vecs[10] = mk(1,0,0, 0,  0,  0, 1,159,119, 'b00011, 159,119, 2, 4);
        vecs[11] = mk(1,0,1, 0,  0,  0, 1, 80, 60, 'b10001,  80, 60, 2, 5);
        vecs[12] = mk(1,0,1, 0,  0,  0, 1,  9,  9, 'b10000,   0,  0, 0, 5);
        vecs[13] = mk(0,0,0, 0,  0,  0, 0,  0,  0, 'b00000,   0,  0, 0, 5);
        vecs[14] = mk(0,0,0, 0,  0,  0, 0,  0,  0, 'b00000,   0,  0, 0, 5);

        // Reset held with start high: everything idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {done, error, vga_plot, fill_start, circ_start}, 5'b0);
        check("rst_count", pixel_count, 16'd0);
        check("rst_to_flags", {done_t, error_t, fill_start_t}, 3'b0);
        rst = 1'b0;
        @(negedge clk);
        check("fill_after_rst", fill_start, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check("abort_fill", {fill_start, done}, 2'b00);

        // Vector table run.
        bg_colour = 3'd5; fg_colour = 3'd2; centre_x = 8'd80; centre_y = 7'd60; radius = 8'd10;
        fill_col = 3'd5; circ_col = 3'd2;
        for (int i = 0; i < 15; i++) begin
            start = vecs[i].start; fill_done = vecs[i].fd; circ_done = vecs[i].cd;
            fill_plot = vecs[i].fp; fill_x = vecs[i].fx; fill_y = vecs[i].fy;
            circ_plot = vecs[i].cp; circ_x = vecs[i].cx; circ_y = vecs[i].cy;
            @(negedge clk);
            check($sformatf("vec%0d_flags", i), {done, error, fill_start, circ_start, vga_plot},
                  vecs[i].flags);
            check($sformatf("vec%0d_count", i), pixel_count, vecs[i].ecnt);
            if (vecs[i].flags[0])
                check($sformatf("vec%0d_pix", i), {vga_x, vga_y, vga_colour},
                      {vecs[i].ex, vecs[i].ey, vecs[i].ecol});
        end
        check("latch_params", {fill_colour, circ_colour, circ_cx, circ_cy, circ_r},
              {3'd5, 3'd2, 8'd80, 7'd60, 8'd10});

        // Full run: 19200 fill pixels then 100 circle pixels.
        bg_colour = 3'd0; fg_colour = 3'd2; fill_col = 3'd0; circ_col = 3'd2;
        start = 1'b1;
        @(negedge clk);
        check("run_fill_start", fill_start, 1'b1);
        check("run_count_clr", pixel_count, 16'd0);
        for (int i = 0; i < 19200; i++) begin
            fill_plot = 1'b1; fill_x = 8'(i % 160); fill_y = 7'(i / 160);
            @(negedge clk);
            check("run_fill_px", {vga_plot, vga_x, vga_y, vga_colour},
                  {1'b1, 8'(i % 160), 7'(i / 160), 3'd0});
        end
        fill_plot = 1'b0; fill_done = 1'b1;
        @(negedge clk);
        check("run_fill_rel", {fill_start, circ_start}, 2'b00);
        check("run_fill_count", pixel_count, 16'd19200);
        fill_done = 1'b0;
        @(negedge clk);
        check("run_circ_start", circ_start, 1'b1);
        for (int k = 0; k < 100; k++) begin
            circ_plot = 1'b1; circ_x = 8'(75 + k % 10); circ_y = 7'(55 + k / 10);
            @(negedge clk);
            check("run_circ_px", {vga_plot, vga_x, vga_y, vga_colour},
                  {1'b1, 8'(75 + k % 10), 7'(55 + k / 10), 3'd2});
        end
        circ_plot = 1'b0; circ_done = 1'b1;
        @(negedge clk);
        check("run_done", {done, error, circ_start}, 3'b100);
        check("run_count", pixel_count, 16'd19300);
        start = 1'b0;
        @(negedge clk);
        check("run_done_drop", done, 1'b0);
        check("run_count_hold", pixel_count, 16'd19300);
        circ_done = 1'b0;

        // Abort mid-circle, then restart with new parameters.
        bg_colour = 3'd3; fg_colour = 3'd6; centre_x = 8'd20; centre_y = 7'd30; radius = 8'd5;
        start = 1'b1;
        @(negedge clk);
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        @(negedge clk);
        check("abort_in_circ", circ_start, 1'b1);
        circ_plot = 1'b1; circ_x = 8'd10; circ_y = 7'd10;
        @(negedge clk);
        check("abort_pre_plot", {vga_plot, pixel_count}, {1'b1, 16'd1});
        start = 1'b0; circ_x = 8'd12; circ_y = 7'd12;
        @(negedge clk);
        check("abort_flags", {circ_start, vga_plot, done}, 3'b000);
        check("abort_count", pixel_count, 16'd1);
        circ_plot = 1'b0;
        bg_colour = 3'd1; fg_colour = 3'd7; centre_x = 8'd100; centre_y = 7'd50; radius = 8'd20;
        start = 1'b1;
        @(negedge clk);
        check("relatch", {fill_colour, circ_colour, circ_cx, circ_cy, circ_r},
              {3'd1, 3'd7, 8'd100, 7'd50, 8'd20});
        check("relatch_count", pixel_count, 16'd0);

        // Reset in FILL beats a pending plot and clears latched params.
        rst = 1'b1; fill_plot = 1'b1; fill_x = 8'd4; fill_y = 7'd4;
        @(negedge clk);
        check("rst_mid_flags", {fill_start, vga_plot, done}, 3'b000);
        check("rst_mid_params", {fill_colour, circ_colour, circ_cx, circ_cy, circ_r}, 29'd0);
        rst = 1'b0; start = 1'b0; fill_plot = 1'b0;
        @(negedge clk);

        // Timeout on the 100-cycle instance.
        start_to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("to_fill", {fill_start_t, error_t, done_t}, 3'b100);
        end
        @(negedge clk);
        check("to_err", {fill_start_t, error_t, done_t}, 3'b011);
        start_to = 1'b0;
        @(negedge clk);
        check("to_idle", {fill_start_t, error_t, done_t}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
